// File: rtl/alu_div_seq_if.sv
// alu_div_seq request/result bus and shared opcode package.
// Master is the ALU side, slave is the divider.
package alu_div_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_DIV  = 4'd8,
    ALU_DIVU = 4'd9,
    ALU_REM  = 4'd10,
    ALU_REMU = 4'd11
  } alu_opcode_e;
endpackage

interface alu_div_if #(
  parameter int WIDTH = 32
) ();
  import alu_div_pkg::*;

  logic             enable_i;
  alu_opcode_e      operator_i;
  logic [WIDTH-1:0] operand_a_i;
  logic [WIDTH-1:0] operand_b_i;
  logic             ex_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             valid_o;
  logic             ready_o;

  modport master (
    output enable_i, operator_i, operand_a_i,
    output operand_b_i, ex_ready_i,
    input  result_o, valid_o, ready_o
  );

  modport slave (
    input  enable_i, operator_i, operand_a_i,
    input  operand_b_i, ex_ready_i,
    output result_o, valid_o, ready_o
  );
endinterface

// File: rtl/alu_div_seq.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU.
// ALU_DIV_EARLY_OUT_EN: skip leading zero bits of |a|.
module alu_div_seq
  import alu_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic       clk,
  input  logic       rst,
  alu_div_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, PREP, ITER, FIX, DONE
  } state_e;

  state_e           state;
  state_e           state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] res_q;
  logic             sgn_q;
  logic             remf_q;
  logic             qneg_q;
  logic             rneg_q;
  logic [CNT_W-1:0] cnt_q;

  logic             op_ok;
  logic             accept;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] pre_a;
  logic [CNT_W-1:0] n_load;

  assign op_ok = (bus.operator_i == ALU_DIV)  ||
                 (bus.operator_i == ALU_DIVU) ||
                 (bus.operator_i == ALU_REM)  ||
                 (bus.operator_i == ALU_REMU);
  assign accept = (state == IDLE) && bus.enable_i && op_ok;

  assign abs_a = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
  assign abs_b = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
  assign trial = {rem_q, a_q[WIDTH-1]} - {1'b0, b_q};

`ifdef ALU_DIV_EARLY_OUT_EN
  // Significant-bit count of |a|, at least one
  always_comb begin
    n_load = CNT_W'(1);
    for (int i = 0; i < WIDTH; i++)
      if (abs_a[i]) n_load = CNT_W'(i + 1);
  end
  assign pre_a = abs_a << (CNT_W'(WIDTH) - n_load);
`else
  assign n_load = CNT_W'(WIDTH);
  assign pre_a  = abs_a;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    valid    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (accept) state_nx = PREP;
      end
      PREP:
        state_nx = (b_q == '0) ? DONE : ITER;
      ITER:
        if (cnt_q == CNT_W'(1)) state_nx = FIX;
      FIX:
        state_nx = DONE;
      DONE: begin
        valid = 1'b1;
        if (bus.ex_ready_i) state_nx = IDLE;
      end
      default:
        state_nx = IDLE;
    endcase
  end

  // Datapath: capture, normalise, iterate, sign-fix
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      res_q  <= '0;
      sgn_q  <= 1'b0;
      remf_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE:
          if (accept) begin
            a_q    <= bus.operand_a_i;
            b_q    <= bus.operand_b_i;
            sgn_q  <= (bus.operator_i == ALU_DIV) ||
                      (bus.operator_i == ALU_REM);
            remf_q <= (bus.operator_i == ALU_REM) ||
                      (bus.operator_i == ALU_REMU);
          end
        PREP: begin
          qneg_q <= sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rneg_q <= sgn_q && a_q[WIDTH-1];
          cnt_q  <= n_load;
          rem_q  <= '0;
          if (b_q == '0) begin
            res_q <= remf_q ? a_q : '1;
          end else begin
            a_q <= pre_a;
            b_q <= abs_b;
          end
        end
        ITER: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (!trial[WIDTH]) begin
            rem_q <= trial[WIDTH-1:0];
            a_q   <= {a_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= {rem_q[WIDTH-2:0], a_q[WIDTH-1]};
            a_q   <= {a_q[WIDTH-2:0], 1'b0};
          end
        end
        FIX:
          if (remf_q) res_q <= rneg_q ? -rem_q : rem_q;
          else        res_q <= qneg_q ? -a_q : a_q;
        default: ;
      endcase
    end
  end

  assign bus.ready_o  = ready;
  assign bus.valid_o  = valid;
  assign bus.result_o = valid ? res_q : '0;

endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq at WIDTH=32.
// Directed vectors; monitor checks result and latency.
module tb_alu_div_seq;
  import alu_div_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    int           t;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  logic         in_done = 1'b0;
  logic         hand_pend = 1'b0;
  logic [W-1:0] held = '0;

  alu_div_if #(.WIDTH(W)) bus ();

  alu_div_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h cyc=%0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input alu_opcode_e op,
                                input logic [W-1:0] a,
                                input logic [W-1:0] b);
    logic [W-1:0] m;
    int s;
    if (b == '0) return 2;
`ifdef ALU_DIV_EARLY_OUT_EN
    m = a;
    if ((op == ALU_DIV || op == ALU_REM) && a[W-1])
      m = -a;
    s = 1;
    for (int i = 0; i < W; i++)
      if (m[i]) s = i + 1;
    return s + 3;
`else
    m = a;
    s = W;
    return s + 3;
`endif
  endfunction

  // Monitor: pops on first valid, checks hold and bubble
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid_o) begin
        if (!in_done) begin
          in_done = 1'b1;
          held = bus.result_o;
          if (sb.size() == 0) begin
            chk("unexpected_valid", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", bus.result_o, e.res);
            chk("latency", W'(cyc - e.t), W'(e.lat));
          end
        end else begin
          chk("hold_stable", bus.result_o, held);
        end
        if (bus.ex_ready_i) hand_pend = 1'b1;
      end else begin
        in_done = 1'b0;
        chk("res_zero", bus.result_o, '0);
        if (hand_pend) begin
          chk("ready_after", W'(bus.ready_o), 1);
          hand_pend = 1'b0;
        end
      end
    end
  end

  task automatic issue(input alu_opcode_e op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [W-1:0] exp,
                       input bit push);
    chk("issue_ready", W'(bus.ready_o), 1);
    bus.enable_i    = 1'b1;
    bus.operator_i  = op;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    if (push) sb.push_back('{exp, cyc, lat_of(op, a, b)});
    @(posedge clk);
    @(negedge clk);
    bus.enable_i    = 1'b0;
    bus.operand_a_i = $urandom;
    bus.operand_b_i = $urandom;
    chk("busy", W'(bus.ready_o), 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && !bus.ready_o; i++)
      @(negedge clk);
    if (!bus.ready_o) begin
      $display("FAIL timeout_idle act=0 exp=1");
      bad++;
      total++;
    end
  endtask

  task automatic run(input alu_opcode_e op,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic [W-1:0] exp);
    issue(op, a, b, exp, 1'b1);
    wait_idle();
  endtask

  initial begin
    bus.enable_i    = 1'b0;
    bus.operator_i  = ALU_ADD;
    bus.operand_a_i = '0;
    bus.operand_b_i = '0;
    bus.ex_ready_i  = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", W'(bus.ready_o), 1);
    chk("rst_valid", W'(bus.valid_o), 0);
    chk("rst_result", bus.result_o, '0);
    rst = 1'b0;
    @(negedge clk);

    run(ALU_DIVU, 32'd100, 32'd7, 32'd14);
    run(ALU_REMU, 32'd100, 32'd7, 32'd2);
    run(ALU_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD);
    run(ALU_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF);
    run(ALU_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1);
    run(ALU_DIV, 32'd7, -32'sd2, 32'hFFFF_FFFD);
    run(ALU_REM, 32'd7, -32'sd2, 32'd1);
    run(ALU_DIV, -32'sd7, -32'sd2, 32'd3);
    run(ALU_REM, -32'sd7, -32'sd2, 32'hFFFF_FFFF);
    run(ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run(ALU_REM, 32'd5, 32'd0, 32'd5);
    run(ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000);
    run(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run(ALU_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000);
    run(ALU_DIVU, 32'h8000_0000, 32'd2, 32'h4000_0000);
    run(ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    run(ALU_REMU, 32'd0, 32'd3, 32'd0);

    // Invalid opcode is ignored
    bus.enable_i   = 1'b1;
    bus.operator_i = ALU_ADD;
    @(negedge clk);
    bus.enable_i = 1'b0;
    chk("bad_op_ready", W'(bus.ready_o), 1);
    @(negedge clk);
    chk("bad_op_valid", W'(bus.valid_o), 0);

    // Hold in DONE with new requests offered
    bus.ex_ready_i = 1'b0;
    issue(ALU_DIVU, 32'd1000, 32'd9, 32'd111, 1'b1);
    for (int i = 0; i < 200 && !bus.valid_o; i++)
      @(negedge clk);
    chk("hold_reached", W'(bus.valid_o), 1);
    for (int i = 0; i < 10; i++) begin
      bus.enable_i    = 1'b1;
      bus.operator_i  = ALU_DIV;
      bus.operand_a_i = $urandom;
      bus.operand_b_i = $urandom;
      @(negedge clk);
      chk("hold_busy", W'(bus.ready_o), 0);
    end
    bus.ex_ready_i = 1'b1;
    @(negedge clk);
    bus.enable_i = 1'b0;
    @(negedge clk);
    chk("bubble_ready", W'(bus.ready_o), 1);
    chk("bubble_valid", W'(bus.valid_o), 0);

    // Reset mid-iteration drops the request
    issue(ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", W'(bus.ready_o), 1);
    chk("midrst_valid", W'(bus.valid_o), 0);
    rst = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.valid_o) seen = 1'b1;
      end
      chk("midrst_novalid", W'(seen), 0);
    end

    // Reset and request together: reset wins
    rst             = 1'b1;
    bus.enable_i    = 1'b1;
    bus.operator_i  = ALU_DIV;
    bus.operand_a_i = 32'd9;
    bus.operand_b_i = 32'd3;
    @(negedge clk);
    chk("rstreq_ready0", W'(bus.ready_o), 1);
    rst          = 1'b0;
    bus.enable_i = 1'b0;
    @(negedge clk);
    chk("rstreq_ready1", W'(bus.ready_o), 1);
    chk("rstreq_valid", W'(bus.valid_o), 0);

    run(ALU_DIVU, 32'd6, 32'd3, 32'd2);
    repeat (3) @(negedge clk);
    chk("sb_empty", W'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
